// File: rtl/ofdm_symbol_scheduler.sv
// ofdm_symbol_scheduler: sequences one SIGNAL symbol then N DATA symbols from two coded
// byte streams into an AXI-Stream byte output with per-symbol tlast and rate tagging.
module ofdm_symbol_scheduler #(
    parameter int NSYM_W = 12
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [NSYM_W+3:0] cmd_tdata,
    input  logic              cmd_tvalid,
    output logic              cmd_tready,
    input  logic [7:0]        s_sig_tdata,
    input  logic              s_sig_tvalid,
    output logic              s_sig_tready,
    input  logic [7:0]        s_dat_tdata,
    input  logic              s_dat_tvalid,
    output logic              s_dat_tready,
    output logic [7:0]        m_axis_tdata,
    output logic [3:0]        m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              done,
    output logic              cmd_err
);
    localparam logic [3:0] RATE_6M = 4'b1011;

    typedef enum logic [1:0] {IDLE, SIG, DATA, FLUSH} state_t;

    state_t              state, state_nxt;
    logic [3:0]          rate_q;
    logic [NSYM_W-1:0]   nsym_q, sym_cnt, nsym_last;
    logic [5:0]          byte_cnt, bps, rate_bps;
    logic                load_en, cmd_hs, rate_ok, in_hs, sym_end, drained;
    logic [7:0]          in_data;

    // Every valid RATE code has bit 3 set; bits [1:0] select the BPSK/QPSK/16QAM/64QAM group.
    assign rate_ok   = cmd_tdata[3];
    assign rate_bps  = rate_q[1:0] == 2'b11 ? 6'd6  :
                       rate_q[1:0] == 2'b10 ? 6'd12 :
                       rate_q[1:0] == 2'b01 ? 6'd24 : 6'd36;
    assign bps       = state == SIG ? 6'd6 : rate_bps;
    assign nsym_last = nsym_q - NSYM_W'(1);

    assign load_en      = ~m_axis_tvalid | m_axis_tready;
    assign drained      = ~m_axis_tvalid | m_axis_tready;
    assign cmd_tready   = aresetn & (state == IDLE) & ~done;
    assign s_sig_tready = (state == SIG) & load_en;
    assign s_dat_tready = (state == DATA) & load_en;
    assign cmd_hs       = cmd_tvalid & cmd_tready;
    assign in_hs        = (s_sig_tvalid & s_sig_tready) | (s_dat_tvalid & s_dat_tready);
    assign in_data      = state == SIG ? s_sig_tdata : s_dat_tdata;
    assign sym_end      = byte_cnt == bps - 6'd1;

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = cmd_hs && rate_ok ? SIG : IDLE;
            SIG:   state_nxt = in_hs && sym_end ? (nsym_q == '0 ? FLUSH : DATA) : SIG;
            DATA:  state_nxt = in_hs && sym_end && sym_cnt == nsym_last ? FLUSH : DATA;
            FLUSH: state_nxt = drained ? IDLE : FLUSH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rate_q        <= '0;
            nsym_q        <= '0;
            sym_cnt       <= '0;
            byte_cnt      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cmd_err       <= 1'b0;
        end else begin
            done    <= state == FLUSH && drained;
            cmd_err <= cmd_hs && !rate_ok;
            if (cmd_hs && rate_ok) begin
                rate_q   <= cmd_tdata[3:0];
                nsym_q   <= cmd_tdata[4 +: NSYM_W];
                sym_cnt  <= '0;
                byte_cnt <= '0;
                busy     <= 1'b1;
            end
            if (state == FLUSH && drained)
                busy <= 1'b0;
            if (in_hs) begin
                byte_cnt      <= sym_end ? 6'd0 : byte_cnt + 6'd1;
                sym_cnt       <= state == DATA && sym_end ? sym_cnt + NSYM_W'(1) : sym_cnt;
                m_axis_tdata  <= in_data;
                m_axis_tuser  <= state == SIG ? RATE_6M : rate_q;
                m_axis_tlast  <= sym_end;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// tb_ofdm_symbol_scheduler: randomized scoreboard bench; a frame-level model predicts the
// byte/tag/tlast sequence, a negedge monitor checks outputs, done timing and backpressure holds.
module tb_ofdm_symbol_scheduler;
    localparam int NSYM_W = 12;
    localparam logic [3:0] R6 = 4'b1011, R9 = 4'b1111, R12 = 4'b1010, R18 = 4'b1110,
                           R24 = 4'b1001, R36 = 4'b1101, R48 = 4'b1000, R54 = 4'b1100;

    logic              aclk = 0, aresetn = 0;
    logic [NSYM_W+3:0] cmd_tdata = 0;
    logic              cmd_tvalid = 0, cmd_tready;
    logic [7:0]        s_sig_tdata = 0, s_dat_tdata = 0;
    logic              s_sig_tvalid = 0, s_sig_tready, s_dat_tvalid = 0, s_dat_tready;
    logic [7:0]        m_axis_tdata;
    logic [3:0]        m_axis_tuser;
    logic              m_axis_tlast, m_axis_tvalid, m_axis_tready = 0;
    logic              busy, done, cmd_err;

    ofdm_symbol_scheduler #(.NSYM_W(NSYM_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
        .s_sig_tdata(s_sig_tdata), .s_sig_tvalid(s_sig_tvalid), .s_sig_tready(s_sig_tready),
        .s_dat_tdata(s_dat_tdata), .s_dat_tvalid(s_dat_tvalid), .s_dat_tready(s_dat_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [7:0] d; logic [3:0] u; logic l; logic fe; } exp_t;

    exp_t       exp_q[$];
    logic [7:0] sig_q[$], dat_q[$];
    int tests = 0, failed = 0, out_cnt = 0, done_cnt = 0, dat_stall = 0, mode = 0;
    bit src_rand = 0, sig_hs = 0, dat_hs = 0, fe_prev = 0, prev_stall = 0, dat_rdy_seen = 0;
    logic [7:0] pd;
    logic [3:0] pu;
    logic       pl;

    function automatic int bps_of(input logic [3:0] r);
        case (r)
            R6, R9:   return 6;
            R12, R18: return 12;
            R24, R36: return 24;
            default:  return 36;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Upstream sources and sink-side ready pattern, driven just after each rising edge.
    always @(posedge aclk) begin
        logic [7:0] tmp;
        #1;
        if (!aresetn) begin
            sig_q.delete(); dat_q.delete(); dat_stall = 0;
            s_sig_tvalid = 0; s_dat_tvalid = 0; s_sig_tdata = 0; s_dat_tdata = 0;
            m_axis_tready = 0;
        end else begin
            if (sig_hs) tmp = sig_q.pop_front();
            if (dat_hs) tmp = dat_q.pop_front();
            s_sig_tvalid = sig_q.size() != 0 && (!src_rand || $urandom_range(0, 3) != 0);
            s_sig_tdata  = sig_q.size() != 0 ? sig_q[0] : 8'h00;
            if (dat_stall > 0) begin
                dat_stall--;
                s_dat_tvalid = 0;
            end else
                s_dat_tvalid = dat_q.size() != 0 && (!src_rand || $urandom_range(0, 3) != 0);
            s_dat_tdata = dat_q.size() != 0 ? dat_q[0] : 8'h00;
            m_axis_tready = mode == 0 ? 1'b1 : mode == 1 ? ~m_axis_tready : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: output scoreboard, done timing, and hold-under-backpressure.
    always @(negedge aclk) begin
        exp_t e;
        if (!aresetn) begin
            sig_hs = 0; dat_hs = 0; fe_prev = 0; prev_stall = 0;
        end else begin
            if (s_dat_tready) dat_rdy_seen = 1;
            if (done || fe_prev) begin
                tests++;
                if (done !== fe_prev) begin
                    failed++;
                    $display("FAIL done_timing: got %b want %b", done, fe_prev);
                end
            end
            if (done) done_cnt++;
            if (prev_stall) begin
                tests++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tuser !== pu || m_axis_tlast !== pl) begin
                    failed++;
                    $display("FAIL hold: got v=%b d=%h u=%h l=%b want v=1 d=%h u=%h l=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, pd, pu, pl);
                end
            end
            fe_prev = 0;
            if (m_axis_tvalid && m_axis_tready) begin
                out_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL out_unexpected: got d=%h u=%h l=%b want nothing", m_axis_tdata, m_axis_tuser, m_axis_tlast);
                end else begin
                    e = exp_q.pop_front();
                    fe_prev = e.fe;
                    if (m_axis_tdata !== e.d || m_axis_tuser !== e.u || m_axis_tlast !== e.l) begin
                        failed++;
                        $display("FAIL out[%0d]: got d=%h u=%h l=%b want d=%h u=%h l=%b",
                                 out_cnt, m_axis_tdata, m_axis_tuser, m_axis_tlast, e.d, e.u, e.l);
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata; pu = m_axis_tuser; pl = m_axis_tlast;
            sig_hs = s_sig_tvalid && s_sig_tready;
            dat_hs = s_dat_tvalid && s_dat_tready;
        end
    end

    // Frame model: 6 SIGNAL bytes at 6M, then nsym symbols of bps(rate) bytes, tlast per symbol.
    task automatic prep(input logic [3:0] r, input int n);
        exp_t e;
        int   b = bps_of(r);
        for (int i = 0; i < 6; i++) begin
            e.d = 8'($urandom); e.u = R6; e.l = (i == 5); e.fe = (i == 5) && (n == 0);
            sig_q.push_back(e.d); exp_q.push_back(e);
        end
        for (int i = 0; i < n * b; i++) begin
            e.d = 8'($urandom); e.u = r; e.l = (i % b == b - 1); e.fe = (i == n * b - 1);
            dat_q.push_back(e.d); exp_q.push_back(e);
        end
        out_cnt = 0;
    endtask

    task automatic send_cmd(input logic [3:0] r, input int n);
        bit ok = 0;
        @(posedge aclk); #1;
        cmd_tdata = {NSYM_W'(n), r};
        cmd_tvalid = 1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge aclk);
            ok = cmd_tready;
        end
        if (!ok) chk("cmd_accept_timeout", 0, 1);
        @(posedge aclk); #1;
        cmd_tvalid = 0;
    endtask

    task automatic wait_done(input int limit);
        bit ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge aclk);
            ok = done;
        end
        chk("done_seen", ok, 1);
        if (ok) chk("cmd_tready_at_done", cmd_tready, 0);
        chk("exp_q_empty", exp_q.size(), 0);
        @(negedge aclk);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic wait_out(input int n);
        for (int i = 0; i < 2000 && out_cnt < n; i++) @(negedge aclk);
        chk("wait_out", out_cnt >= n, 1);
    endtask

    task automatic run_frame(input logic [3:0] r, input int n);
        prep(r, n);
        send_cmd(r, n);
        @(negedge aclk);
        chk("busy_after_cmd", busy, 1);
        chk("no_cmd_err", cmd_err, 0);
        wait_done(400 + 8 * (n * bps_of(r) + 6));
    endtask

    task automatic chk_reset_vals();
        chk("rst_cmd_tready", cmd_tready, 0);
        chk("rst_sig_tready", s_sig_tready, 0);
        chk("rst_dat_tready", s_dat_tready, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_err", cmd_err, 0);
    endtask

    initial begin
        logic [3:0] rates [8];
        int dc;
        rates = '{R6, R9, R12, R18, R24, R36, R48, R54};
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk_reset_vals();
        @(posedge aclk); #1 aresetn = 1;
        @(negedge aclk);
        chk("idle_cmd_tready", cmd_tready, 1);

        run_frame(R6, 2);
        mode = 1;
        run_frame(R54, 3);
        mode = 0;
        dat_rdy_seen = 0;
        run_frame(R24, 0);
        chk("nsym0_no_dat_tready", dat_rdy_seen, 0);

        send_cmd(4'b0000, 5);
        @(negedge aclk);
        chk("bad_cmd_err", cmd_err, 1);
        chk("bad_cmd_busy", busy, 0);
        chk("bad_cmd_sig_rdy", s_sig_tready, 0);
        chk("bad_cmd_dat_rdy", s_dat_tready, 0);
        @(negedge aclk);
        chk("bad_cmd_err_pulse", cmd_err, 0);
        run_frame(R36, 1);

        prep(R12, 2);
        send_cmd(R12, 2);
        wait_out(11);
        dat_stall = 10;
        wait_out(22);
        dc = done_cnt;
        @(posedge aclk); #1 aresetn = 0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk_reset_vals();
        exp_q.delete();
        @(posedge aclk); #1 aresetn = 1;
        repeat (4) @(negedge aclk);
        chk("no_done_after_reset", done_cnt, dc);
        run_frame(R12, 2);

        mode = 2;
        src_rand = 1;
        for (int k = 0; k < 8; k++)
            run_frame(rates[$urandom_range(0, 7)], $urandom_range(0, 3));
        mode = 0;
        src_rand = 0;
        run_frame(R6, (1 << NSYM_W) - 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
